mem_lsu: RTL and testbench

Load/store unit for the MEM stage and initiator on the data-memory port. Takes one load or store request per transaction from the pipeline: byte address, RISC-V funct3 size/sign code, store data. Drives the word-indexed data memory (asynchronous read, write on rising clock edge) and returns the formatted load result. Sub-word stores use read-modify-write. Misaligned, illegal and out-of-range requests are faulted and never reach memory.

---
 rtl/mem_lsu.sv | 151 +++++++++++++++
 tb/tb_mem_lsu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Load/store unit for the MEM stage: runs one load or store per transaction against a
// word-indexed data memory, merges sub-word stores by read-modify-write, and faults bad requests.
module mem_lsu #(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0C00,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault,
  output logic [31:0] o_load_data,
  output logic        o_memread,
  output logic        o_memwrite,
  output logic [31:0] o_address,
  output logic [31:0] o_write_data,
  input  logic [31:0] i_read_data
);

  localparam logic [31:0] MEM_LAST = MEM_BASE + 32'(MEM_WORDS) - 32'd1;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state, state_next;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] word_q;
  logic        fault_q;
  logic [31:0] load_q;

  logic        illegal, misaligned, out_of_range, fault_now;
  logic [31:0] req_index;
  logic [4:0]  byte_sh, half_sh;
  logic [31:0] rd_byte_shifted, rd_half_shifted;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_fmt;
  logic [31:0] merged;

  // Request checks on the raw inputs so the decision is made in the acceptance cycle.
  always_comb begin
    req_index = {2'b00, i_addr[31:2]};
    if (i_we)
      illegal = !(i_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      illegal = !(i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned   = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                   ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    out_of_range = (req_index < MEM_BASE) || (req_index > MEM_LAST);
    fault_now    = illegal || misaligned || out_of_range;
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    byte_sh         = {addr_q[1:0], 3'b000};
    half_sh         = {addr_q[1], 4'b0000};
    rd_byte_shifted = i_read_data >> byte_sh;
    rd_half_shifted = i_read_data >> half_sh;
    rd_byte         = rd_byte_shifted[7:0];
    rd_half         = rd_half_shifted[15:0];
    case (funct3_q)
      3'b000:  load_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_fmt = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_fmt = {24'h000000, rd_byte};
      3'b101:  load_fmt = {16'h0000, rd_half};
      default: load_fmt = i_read_data;
    endcase
    if (funct3_q[1:0] == 2'b01)
      merged = (i_read_data & ~(32'h0000_FFFF << half_sh)) | ({16'h0000, word_q[15:0]} << half_sh);
    else
      merged = (i_read_data & ~(32'h0000_00FF << byte_sh)) | ({24'h000000, word_q[7:0]} << byte_sh);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (i_valid) begin
        if (fault_now)                  state_next = RESP;
        else if (i_we && i_funct3 == 3'b010) state_next = WR;
        else                            state_next = RD;
      end
      RD:      state_next = we_q ? WR : RESP;
      WR:      state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  // word_q holds the store data until RD replaces it with the merged word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      word_q   <= '0;
      fault_q  <= 1'b0;
      load_q   <= '0;
    end else begin
      if (state == IDLE && i_valid) begin
        we_q     <= i_we;
        funct3_q <= i_funct3;
        addr_q   <= i_addr;
        word_q   <= i_wdata;
        fault_q  <= fault_now;
      end
      if (state == RD) begin
        if (we_q) word_q <= merged;
        else      load_q <= load_fmt;
      end
    end
  end

  always_comb begin
    o_busy       = 1'b1;
    o_done       = 1'b0;
    o_fault      = 1'b0;
    o_memread    = 1'b0;
    o_memwrite   = 1'b0;
    o_address    = '0;
    o_write_data = '0;
    case (state)
      IDLE: o_busy = 1'b0;
      RD: begin
        o_memread = 1'b1;
        o_address = {2'b00, addr_q[31:2]};
      end
      WR: begin
        o_memwrite   = 1'b1;
        o_address    = {2'b00, addr_q[31:2]};
        o_write_data = word_q;
      end
      default: begin
        o_done  = 1'b1;
        o_fault = fault_q;
      end
    endcase
  end

  assign o_load_data = load_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a behavioural 256-word data memory
// (asynchronous read, write on rising edge).
module tb_mem_lsu;

  logic        i_clk = 1'b0;
  logic        i_reset, i_valid, i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata, i_read_data;
  logic        o_busy, o_done, o_fault, o_memread, o_memwrite;
  logic [31:0] o_load_data, o_address, o_write_data;

  int unsigned npass = 0;
  int unsigned ntotal = 0;

  mem_lsu #(.MEM_BASE(32'h0000_0C00), .MEM_WORDS(256)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_we(i_we),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_busy(o_busy), .o_done(o_done), .o_fault(o_fault), .o_load_data(o_load_data),
    .o_memread(o_memread), .o_memwrite(o_memwrite), .o_address(o_address),
    .o_write_data(o_write_data), .i_read_data(i_read_data)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0] mem [0:255];
  logic [31:0] midx;
  logic        in_rng;
  assign midx   = o_address - 32'h0000_0C00;
  assign in_rng = (o_address >= 32'h0000_0C00) && (o_address < 32'h0000_0D00);
  always_comb i_read_data = (o_memread && in_rng) ? mem[midx[7:0]] : '0;
  always @(posedge i_clk) if (o_memwrite && in_rng) mem[midx[7:0]] <= o_write_data;

  // Per-sample records of the last transaction; sample k is the k-th cycle after acceptance.
  logic        s_rd [1:9];
  logic        s_wr [1:9];
  logic        s_busy [1:9];
  logic        s_done [1:9];
  logic [31:0] s_adr [1:9];
  logic [31:0] s_wd [1:9];
  int          done_at, strobes, both_high, idle_nz;
  logic        fault_at;
  logic [31:0] ld_at;

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge i_clk);
    i_valid = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    @(posedge i_clk);
    done_at = 0; strobes = 0; both_high = 0; idle_nz = 0; fault_at = 1'b0; ld_at = '0;
    for (int k = 1; k <= 8 && done_at == 0; k++) begin
      @(negedge i_clk);
      if (k == 1) i_valid = 1'b0;
      s_rd[k] = o_memread; s_wr[k] = o_memwrite; s_adr[k] = o_address; s_wd[k] = o_write_data;
      if (o_memread || o_memwrite) strobes++;
      if (o_memread && o_memwrite) both_high++;
      if (!o_memread && !o_memwrite && (o_address != 0 || o_write_data != 0)) idle_nz++;
      if (o_done) begin done_at = k; fault_at = o_fault; ld_at = o_load_data; end
    end
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_valid = 1'b0; i_we = 1'b0; i_funct3 = '0; i_addr = '0; i_wdata = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    ntotal++; if (o_busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", o_busy); else npass++;
    ntotal++; if (o_done !== 1'b0 || o_fault !== 1'b0) $display("FAIL rst_done got=%b%b exp=00", o_done, o_fault); else npass++;
    ntotal++; if (o_memread !== 1'b0 || o_memwrite !== 1'b0) $display("FAIL rst_strobes got=%b%b exp=00", o_memread, o_memwrite); else npass++;
    ntotal++; if (o_address !== 32'h0 || o_write_data !== 32'h0) $display("FAIL rst_bus got=%h/%h exp=0/0", o_address, o_write_data); else npass++;
    ntotal++; if (o_load_data !== 32'h0) $display("FAIL rst_ld got=%h exp=0", o_load_data); else npass++;
    i_reset = 1'b0;
  endtask

  task automatic test_word;
    txn(1'b1, 3'b010, 32'h0000_3004, 32'hDEAD_BEEF);
    ntotal++; if (s_wr[1] !== 1'b1 || s_rd[1] !== 1'b0) $display("FAIL sw_strobe got=rd%b wr%b exp=rd0 wr1", s_rd[1], s_wr[1]); else npass++;
    ntotal++; if (s_adr[1] !== 32'h0000_0C01) $display("FAIL sw_addr got=%h exp=00000c01", s_adr[1]); else npass++;
    ntotal++; if (s_wd[1] !== 32'hDEAD_BEEF) $display("FAIL sw_wdata got=%h exp=deadbeef", s_wd[1]); else npass++;
    ntotal++; if (done_at !== 2 || fault_at !== 1'b0) $display("FAIL sw_done got=%0d f%b exp=2 f0", done_at, fault_at); else npass++;
    ntotal++; if (ld_at !== 32'h0) $display("FAIL sw_ld_held got=%h exp=0", ld_at); else npass++;
    ntotal++; if (both_high !== 0 || idle_nz !== 0) $display("FAIL sw_bus got=%0d/%0d exp=0/0", both_high, idle_nz); else npass++;
    txn(1'b0, 3'b010, 32'h0000_3004, 32'h0);
    ntotal++; if (s_rd[1] !== 1'b1 || s_adr[1] !== 32'h0000_0C01) $display("FAIL lw_rd got=%b %h exp=1 00000c01", s_rd[1], s_adr[1]); else npass++;
    ntotal++; if (done_at !== 2 || ld_at !== 32'hDEAD_BEEF) $display("FAIL lw_data got=%0d %h exp=2 deadbeef", done_at, ld_at); else npass++;
    // Range boundaries: last valid word accepted.
    txn(1'b1, 3'b010, 32'h0000_33FC, 32'h0BAD_F00D);
    txn(1'b0, 3'b010, 32'h0000_33FC, 32'h0);
    ntotal++; if (fault_at !== 1'b0 || ld_at !== 32'h0BAD_F00D) $display("FAIL lw_last got=f%b %h exp=f0 0badf00d", fault_at, ld_at); else npass++;
  endtask

  task automatic test_subword_store;
    txn(1'b1, 3'b000, 32'h0000_3005, 32'h1234_56AA);
    ntotal++; if (s_rd[1] !== 1'b1 || s_wr[1] !== 1'b0) $display("FAIL sb_rd got=rd%b wr%b exp=rd1 wr0", s_rd[1], s_wr[1]); else npass++;
    ntotal++; if (s_wr[2] !== 1'b1 || s_wd[2] !== 32'hDEAD_AAEF) $display("FAIL sb_wr got=%b %h exp=1 deadaaef", s_wr[2], s_wd[2]); else npass++;
    ntotal++; if (done_at !== 3 || fault_at !== 1'b0) $display("FAIL sb_done got=%0d f%b exp=3 f0", done_at, fault_at); else npass++;
    ntotal++; if (mem[1] !== 32'hDEAD_AAEF) $display("FAIL sb_mem got=%h exp=deadaaef", mem[1]); else npass++;
  endtask

  task automatic test_loads;
    logic [2:0]  f3 [0:6];
    logic [31:0] ad [0:6];
    logic [31:0] ex [0:6];
    f3[0] = 3'b000; ad[0] = 32'h3007; ex[0] = 32'hFFFF_FFDE;
    f3[1] = 3'b100; ad[1] = 32'h3007; ex[1] = 32'h0000_00DE;
    f3[2] = 3'b001; ad[2] = 32'h3006; ex[2] = 32'hFFFF_DEAD;
    f3[3] = 3'b101; ad[3] = 32'h3006; ex[3] = 32'h0000_DEAD;
    f3[4] = 3'b000; ad[4] = 32'h3004; ex[4] = 32'hFFFF_FFEF;
    f3[5] = 3'b101; ad[5] = 32'h3004; ex[5] = 32'h0000_AAEF;
    f3[6] = 3'b100; ad[6] = 32'h3005; ex[6] = 32'h0000_00AA;
    for (int i = 0; i < 7; i++) begin
      txn(1'b0, f3[i], ad[i], 32'h0);
      ntotal++;
      if (done_at !== 2 || fault_at !== 1'b0 || ld_at !== ex[i])
        $display("FAIL load%0d got=%0d f%b %h exp=2 f0 %h", i, done_at, fault_at, ld_at, ex[i]);
      else npass++;
    end
  endtask

  task automatic test_faults;
    logic        we [0:5];
    logic [2:0]  f3 [0:5];
    logic [31:0] ad [0:5];
    we[0] = 1'b0; f3[0] = 3'b010; ad[0] = 32'h0000_3002;
    we[1] = 1'b0; f3[1] = 3'b001; ad[1] = 32'h0000_3001;
    we[2] = 1'b1; f3[2] = 3'b100; ad[2] = 32'h0000_3004;
    we[3] = 1'b1; f3[3] = 3'b010; ad[3] = 32'h0000_4000;
    we[4] = 1'b0; f3[4] = 3'b010; ad[4] = 32'h0000_3400;
    we[5] = 1'b0; f3[5] = 3'b010; ad[5] = 32'h0000_2FFC;
    for (int i = 0; i < 6; i++) begin
      txn(we[i], f3[i], ad[i], 32'h5555_5555);
      ntotal++;
      if (done_at !== 1 || fault_at !== 1'b1) $display("FAIL fault%0d_done got=%0d f%b exp=1 f1", i, done_at, fault_at); else npass++;
      ntotal++;
      if (strobes !== 0 || idle_nz !== 0) $display("FAIL fault%0d_bus got=%0d/%0d exp=0/0", i, strobes, idle_nz); else npass++;
      ntotal++;
      if (ld_at !== 32'h0000_00AA) $display("FAIL fault%0d_ld got=%h exp=000000aa", i, ld_at); else npass++;
    end
    ntotal++; if (mem[1] !== 32'hDEAD_AAEF) $display("FAIL fault_mem got=%h exp=deadaaef", mem[1]); else npass++;
  endtask

  task automatic test_back_to_back;
    int dones = 0;
    @(negedge i_clk);
    i_valid = 1'b1; i_we = 1'b1; i_funct3 = 3'b000; i_addr = 32'h0000_3004; i_wdata = 32'h0000_00AA;
    @(posedge i_clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge i_clk);
      s_busy[k] = o_busy; s_rd[k] = o_memread; s_wr[k] = o_memwrite; s_wd[k] = o_write_data; s_done[k] = o_done;
      if (o_done) dones++;
      if (k == 1) i_wdata = 32'h0000_0055;
      if (k == 5) i_valid = 1'b0;
    end
    ntotal++; if (dones !== 2) $display("FAIL b2b_dones got=%0d exp=2", dones); else npass++;
    ntotal++; if (s_done[3] !== 1'b1 || s_done[7] !== 1'b1) $display("FAIL b2b_done_pos got=%b%b exp=11", s_done[3], s_done[7]); else npass++;
    ntotal++; if (s_busy[2] !== 1'b1 || s_busy[4] !== 1'b0 || s_busy[5] !== 1'b1 || s_busy[9] !== 1'b0)
      $display("FAIL b2b_busy got=%b%b%b%b exp=1010", s_busy[2], s_busy[4], s_busy[5], s_busy[9]); else npass++;
    ntotal++; if (s_rd[5] !== 1'b1) $display("FAIL b2b_second_rd got=%b exp=1", s_rd[5]); else npass++;
    ntotal++; if (s_wd[2] !== 32'hDEAD_AAAA || s_wd[6] !== 32'hDEAD_AA55)
      $display("FAIL b2b_wdata got=%h/%h exp=deadaaaa/deadaa55", s_wd[2], s_wd[6]); else npass++;
    ntotal++; if (mem[1] !== 32'hDEAD_AA55) $display("FAIL b2b_mem got=%h exp=deadaa55", mem[1]); else npass++;
  endtask

  task automatic test_reset_mid;
    int wr_seen = 0;
    int done_seen = 0;
    @(negedge i_clk);
    i_valid = 1'b1; i_we = 1'b1; i_funct3 = 3'b001; i_addr = 32'h0000_3004; i_wdata = 32'h0000_9999;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    ntotal++; if (o_memread !== 1'b1) $display("FAIL rstmid_rd got=%b exp=1", o_memread); else npass++;
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    ntotal++; if (o_busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", o_busy); else npass++;
    for (int k = 0; k < 5; k++) begin
      if (o_memwrite) wr_seen++;
      if (o_done) done_seen++;
      @(negedge i_clk);
    end
    ntotal++; if (wr_seen !== 0 || done_seen !== 0) $display("FAIL rstmid_quiet got=wr%0d done%0d exp=0/0", wr_seen, done_seen); else npass++;
    ntotal++; if (mem[1] !== 32'hDEAD_AA55) $display("FAIL rstmid_mem got=%h exp=deadaa55", mem[1]); else npass++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword_store();
    test_loads();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
